// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and BCD helpers for the RTC time keeper.
// Holds the mode encoding, the BCD digit limits and the bit offsets of
// each digit within the packed time word.
package rtc_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HR  = 2'd1,
      MODE_SET_MIN = 2'd2
   } mode_e;

   localparam logic [3:0] SEC_T_MAX     = 4'd5;
   localparam logic [3:0] MIN_T_MAX     = 4'd5;
   localparam logic [3:0] HR_T_MAX      = 4'd2;
   localparam logic [3:0] HR_O_MAX_AT_2 = 4'd3;
   localparam logic [3:0] DIGIT_MAX     = 4'd9;

   // Offsets of each 4-bit digit inside time_bcd
   localparam int SEC_O_LSB = 0;
   localparam int SEC_T_LSB = 4;
   localparam int MIN_O_LSB = 8;
   localparam int MIN_T_LSB = 12;
   localparam int HR_O_LSB  = 16;
   localparam int HR_T_LSB  = 20;

   // True when a two-digit BCD field {tens, ones} sits at its last value
   function automatic logic bcd2_at_max(input logic [7:0] v,
                                        input logic [3:0] t_max,
                                        input logic [3:0] o_max);
      return (v[7:4] == t_max) && (v[3:0] == o_max);
   endfunction

   // Increment a two-digit BCD field, wrapping to 00 after {t_max, o_max}.
   // The ones digit always rolls at 9 below the top tens value, which keeps
   // hours correct (09 -> 10, 19 -> 20, 23 -> 00).
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v,
                                           input logic [3:0] t_max,
                                           input logic [3:0] o_max);
      logic [7:0] r;
      if (bcd2_at_max(v, t_max, o_max))
         r = 8'h00;
      else if (v[3:0] == DIGIT_MAX)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, counting debouncer and rising-edge
// press pulse for one raw push-button. A change is accepted only after the
// synchronized input has differed from the stable value for
// DEBOUNCE_CYCLES consecutive cycles; raw edge to press pulse is
// 2 + DEBOUNCE_CYCLES cycles.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic          stable_dly_q, stable_dly_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronizer shift, debounce counter and stable-value update
   always_comb begin
      sync1_d      = btn_raw;
      sync2_d      = sync1_q;
      stable_dly_d = stable_q;
      stable_d     = stable_q;
      cnt_d        = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST)
            stable_d = sync2_q;
         else
            cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers, all cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         cnt_q        <= cnt_d;
      end
   end

   assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/rtc_time_keeper.sv
// rtc_time_keeper: 1 Hz time base, BCD HH:MM:SS counters and the
// RUN / SET_HR / SET_MIN mode FSM driven by two debounced buttons.
// Optional feature macro RTC_SET_BLINK_EN: blinks the digits being set
// through the registered blank mask; without it blank is tied low.
// CLK_HZ/TICK_HZ must be at least 2.
module rtc_time_keeper
   import rtc_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int TICK_HZ         = 1,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk_50Mhz,
   input  logic        rst,
   input  logic        btn_mode,
   input  logic        btn_inc,
   output logic [23:0] time_bcd,
   output logic        tick_1hz,
   output logic [1:0]  mode,
   output logic [3:0]  blank
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic          mode_p, inc_p;
   mode_e         state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          presc_wrap;
   logic [7:0]    sec_q, sec_d;
   logic [7:0]    min_q, min_d;
   logic [7:0]    hr_q, hr_d;
   logic          tick_q, tick_d;
   logic          enter_set_hr, enter_run, hr_inc, min_inc, run_tick;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk     (clk_50Mhz),
      .rst     (rst),
      .btn_raw (btn_mode),
      .press   (mode_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk     (clk_50Mhz),
      .rst     (rst),
      .btn_raw (btn_inc),
      .press   (inc_p)
   );

   assign presc_wrap = (presc_q == PRESC_LAST);

   // Mode state register
   always_ff @(posedge clk_50Mhz) begin
      if (rst)
         state_q <= MODE_RUN;
      else
         state_q <= state_d;
   end

   // Next mode and per-cycle actions; a mode press always pre-empts an
   // increment press and a tick landing on the same cycle
   always_comb begin
      state_d      = state_q;
      enter_set_hr = 1'b0;
      enter_run    = 1'b0;
      hr_inc       = 1'b0;
      min_inc      = 1'b0;
      run_tick     = 1'b0;
      case (state_q)
         MODE_RUN: begin
            if (mode_p) begin
               state_d      = MODE_SET_HR;
               enter_set_hr = 1'b1;
            end else begin
               run_tick = presc_wrap;
            end
         end
         MODE_SET_HR: begin
            if (mode_p)
               state_d = MODE_SET_MIN;
            else
               hr_inc = inc_p;
         end
         MODE_SET_MIN: begin
            if (mode_p) begin
               state_d   = MODE_RUN;
               enter_run = 1'b1;
            end else begin
               min_inc = inc_p;
            end
         end
         default: state_d = MODE_RUN;
      endcase
   end

   // Free-running prescaler, restarted on return to RUN so the first tick
   // lands a full period after leaving the set modes
   always_comb begin
      presc_d = presc_q + 1'b1;
      if (presc_wrap || enter_run)
         presc_d = '0;
   end

   // BCD time update: ripple carry on a tick, direct field edits while setting
   always_comb begin
      sec_d  = sec_q;
      min_d  = min_q;
      hr_d   = hr_q;
      tick_d = run_tick;
      if (run_tick) begin
         sec_d = bcd2_inc(sec_q, SEC_T_MAX, DIGIT_MAX);
         if (bcd2_at_max(sec_q, SEC_T_MAX, DIGIT_MAX)) begin
            min_d = bcd2_inc(min_q, MIN_T_MAX, DIGIT_MAX);
            if (bcd2_at_max(min_q, MIN_T_MAX, DIGIT_MAX))
               hr_d = bcd2_inc(hr_q, HR_T_MAX, HR_O_MAX_AT_2);
         end
      end
      if (enter_set_hr)
         sec_d = 8'h00;
      if (hr_inc)
         hr_d = bcd2_inc(hr_q, HR_T_MAX, HR_O_MAX_AT_2);
      if (min_inc)
         min_d = bcd2_inc(min_q, MIN_T_MAX, DIGIT_MAX);
   end

   // Datapath registers
   always_ff @(posedge clk_50Mhz) begin
      if (rst) begin
         presc_q <= '0;
         sec_q   <= 8'h00;
         min_q   <= 8'h00;
         hr_q    <= 8'h00;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         tick_q  <= tick_d;
      end
   end

`ifdef RTC_SET_BLINK_EN
   localparam logic [PW-1:0] PRESC_HALF = PW'(DIV / 2);

   logic [3:0] blank_q, blank_d;

   // Blank the field being edited during the second half of each period;
   // computed from next-state values so blank_q lines up with presc_q
   always_comb begin
      blank_d = 4'b0000;
      if (presc_d >= PRESC_HALF) begin
         case (state_d)
            MODE_SET_HR:  blank_d = 4'b1100;
            MODE_SET_MIN: blank_d = 4'b0011;
            default:      blank_d = 4'b0000;
         endcase
      end
   end

   // Blank mask register
   always_ff @(posedge clk_50Mhz) begin
      if (rst)
         blank_q <= 4'b0000;
      else
         blank_q <= blank_d;
   end

   assign blank = blank_q;
`else
   assign blank = 4'b0000;
`endif

   assign time_bcd[HR_T_LSB  +: 4] = hr_q[7:4];
   assign time_bcd[HR_O_LSB  +: 4] = hr_q[3:0];
   assign time_bcd[MIN_T_LSB +: 4] = min_q[7:4];
   assign time_bcd[MIN_O_LSB +: 4] = min_q[3:0];
   assign time_bcd[SEC_T_LSB +: 4] = sec_q[7:4];
   assign time_bcd[SEC_O_LSB +: 4] = sec_q[3:0];
   assign tick_1hz = tick_q;
   assign mode     = state_q;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// tb_rtc_time_keeper: scoreboard bench. The stimulus process drives the
// buttons and advances a seconds-of-day / mode / prescaler-phase model,
// pushing every expected visible event (tick, mode change, time edit) with
// its clock-edge stamp; the monitor pops whenever the DUT outputs change.
module tb_rtc_time_keeper;

   localparam int CLK_HZ  = 10;
   localparam int TICK_HZ = 1;
   localparam int DC      = 4;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int PLAT    = 2 + DC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_mode = 1'b0;
   logic        btn_inc = 1'b0;
   logic [23:0] time_bcd;
   logic        tick_1hz;
   logic [1:0]  mode;
   logic [3:0]  blank;

   rtc_time_keeper #(
      .CLK_HZ          (CLK_HZ),
      .TICK_HZ         (TICK_HZ),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk_50Mhz (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .time_bcd  (time_bcd),
      .tick_1hz  (tick_1hz),
      .mode      (mode),
      .blank     (blank)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          edge_n;
      bit          tick;
      int          md;
      logic [23:0] t;
   } ev_t;

   ev_t         exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          hh, mm, ss, md, phase;
   int          ecnt = 0;
   int          pend_m[$];
   int          pend_i[$];
   logic [3:0]  exp_blank = 4'b0000;
   bit          mon_en = 1'b0;
   logic [1:0]  prev_mode;
   logic [23:0] prev_time;

   function automatic logic [23:0] bcd_time(int h, int m, int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, want);
   endtask

   task automatic push_ev(bit tk);
      ev_t e;
      e.edge_n = ecnt;
      e.tick   = tk;
      e.md     = md;
      e.t      = bcd_time(hh, mm, ss);
      exp_q.push_back(e);
   endtask

   // Behavioural model for one clock edge
   task automatic model_edge();
      bit mp, ip, wrap;
      int t;
      ecnt++;
      if (rst) begin
         hh = 0; mm = 0; ss = 0; md = 0; phase = 0;
         pend_m.delete();
         pend_i.delete();
         exp_blank = 4'b0000;
      end else begin
         mp = 1'b0;
         ip = 1'b0;
         if (pend_m.size() > 0 && pend_m[0] == ecnt) begin mp = 1'b1; void'(pend_m.pop_front()); end
         if (pend_i.size() > 0 && pend_i[0] == ecnt) begin ip = 1'b1; void'(pend_i.pop_front()); end
         wrap = (phase == DIV - 1);
         if (mp) begin
            md = (md + 1) % 3;
            if (md == 1) ss = 0;
            phase = (md == 0) ? 0 : (phase + 1) % DIV;
            push_ev(1'b0);
         end else begin
            if (ip && md == 1) begin hh = (hh + 1) % 24; push_ev(1'b0); end
            else if (ip && md == 2) begin mm = (mm + 1) % 60; push_ev(1'b0); end
            if (md == 0 && wrap) begin
               t  = (hh * 3600 + mm * 60 + ss + 1) % 86400;
               hh = t / 3600;
               mm = (t / 60) % 60;
               ss = t % 60;
               push_ev(1'b1);
            end
            phase = (phase + 1) % DIV;
         end
`ifdef RTC_SET_BLINK_EN
         exp_blank = (md != 0 && phase >= DIV / 2) ? ((md == 1) ? 4'b1100 : 4'b0011) : 4'b0000;
`else
         exp_blank = 4'b0000;
`endif
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
      end
   endtask

   // Hold buttons for 'hold' cycles; holds of DC or more are accepted and
   // take effect 2+DC edges after the first sampling edge
   task automatic press(bit m, bit i, int hold);
      if (m) btn_mode = 1'b1;
      if (i) btn_inc = 1'b1;
      if (hold >= DC) begin
         if (m) pend_m.push_back(ecnt + 1 + PLAT);
         if (i) pend_i.push_back(ecnt + 1 + PLAT);
      end
      step(hold);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(DC + 6);
   endtask

   // Time a mode press so it lands on the prescaler wrap edge
   task automatic press_at_wrap();
      int g;
      g = 0;
      while (((phase + PLAT) % DIV) != DIV - 1 && g < 2 * DIV) begin step(1); g++; end
      press(1'b1, 1'b0, DC + 2);
   endtask

   task automatic do_reset();
      check("drain_before_reset", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      check("rst_time", 32'(time_bcd), 32'd0);
      check("rst_tick", 32'(tick_1hz), 32'd0);
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_blank", 32'(blank), 32'd0);
      exp_q.delete();
      prev_mode = 2'd0;
      prev_time = 24'h0;
      mon_en = 1'b1;
   endtask

   // Monitor: compare blank every cycle and pop an event on any output change
   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         n_chk++;
         if (blank === exp_blank) n_pass++;
         else $display("FAIL blank @edge %0d: got %b want %b", ecnt, blank, exp_blank);
         if (exp_q.size() > 0 && exp_q[0].edge_n < ecnt) begin
            e = exp_q.pop_front();
            n_chk++;
            $display("FAIL missed_event: want edge=%0d tick=%0b mode=%0d time=%06h, no output change",
                     e.edge_n, e.tick, e.md, e.t);
         end
         if (tick_1hz || mode !== prev_mode || time_bcd !== prev_time) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_event @edge %0d: tick=%0b mode=%0d time=%06h",
                        ecnt, tick_1hz, mode, time_bcd);
            end else begin
               e = exp_q.pop_front();
               if (ecnt == e.edge_n && tick_1hz == e.tick && int'(mode) == e.md && time_bcd === e.t)
                  n_pass++;
               else
                  $display("FAIL event: got edge=%0d tick=%0b mode=%0d time=%06h, want edge=%0d tick=%0b mode=%0d time=%06h",
                           ecnt, tick_1hz, mode, time_bcd, e.edge_n, e.tick, e.md, e.t);
            end
         end
         prev_mode = mode;
         prev_time = time_bcd;
      end
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g;
      int r;
      bit b;
      @(negedge clk);
      do_reset();

      // First tick ten cycles after reset, then 600 ticks total
      step(10);
      check("first_tick_time", 32'(time_bcd), 32'h000001);
      step(5990);
      check("t600", 32'(time_bcd), 32'h001000);

      // Short glitch is ignored; a held press enters SET_HR and clears seconds
      press(1'b1, 1'b0, 3);
      check("glitch_mode", 32'(mode), 32'd0);
      press(1'b1, 1'b0, 8);
      check("mode_set_hr", 32'(mode), 32'd1);
      check("sec_cleared", 32'(time_bcd[7:0]), 32'h00);

      // Hours: up to 23, wrap to 00, back to 23
      g = 0;
      while (hh != 23 && g < 30) begin press(1'b0, 1'b1, DC + 2); g++; end
      check("hr_23", 32'(time_bcd[23:16]), 32'h23);
      press(1'b0, 1'b1, DC + 2);
      check("hr_wrap", 32'(time_bcd[23:16]), 32'h00);
      g = 0;
      while (hh != 23 && g < 30) begin press(1'b0, 1'b1, DC + 2); g++; end

      // Both buttons together: mode wins, hours unchanged
      press(1'b1, 1'b1, DC + 2);
      check("both_mode", 32'(mode), 32'd2);
      check("both_hr", 32'(time_bcd[23:16]), 32'h23);

      // Minutes: up to 59, wrap to 00 without touching hours, back to 59
      g = 0;
      while (mm != 59 && g < 70) begin press(1'b0, 1'b1, DC + 2); g++; end
      check("min_59", 32'(time_bcd[15:8]), 32'h59);
      press(1'b0, 1'b1, DC + 2);
      check("min_wrap", 32'(time_bcd), 32'h230000);
      g = 0;
      while (mm != 59 && g < 70) begin press(1'b0, 1'b1, DC + 2); g++; end

      // Back to RUN, run to 23:59:59 and roll over
      press(1'b1, 1'b0, DC + 2);
      check("mode_run", 32'(mode), 32'd0);
      g = 0;
      while (!(hh == 23 && mm == 59 && ss == 59) && g < 1000) begin step(1); g++; end
      check("t235959", 32'(time_bcd), 32'h235959);
      step(DIV);
      check("rollover", 32'(time_bcd), 32'h000000);

      // Mode press on the wrap cycle: no tick, seconds cleared; resume timing
      step(23);
      press_at_wrap();
      check("wrap_mode", 32'(mode), 32'd1);
      check("wrap_sec", 32'(time_bcd[7:0]), 32'h00);
      press(1'b1, 1'b0, DC + 2);
      press(1'b1, 1'b0, DC + 2);
      check("resume_mode", 32'(mode), 32'd0);
      step(3 * DIV);

      // Randomized mix of presses, glitches and idle time
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 5);
         case (r)
            0: step($urandom_range(1, 40));
            1: press(1'b1, 1'b0, $urandom_range(DC, DC + 4));
            2: press(1'b0, 1'b1, $urandom_range(DC, DC + 4));
            3: press(1'b1, 1'b1, $urandom_range(DC, DC + 4));
            4: begin
               b = 1'($urandom_range(0, 1));
               press(b, !b, $urandom_range(1, DC - 1));
            end
            default: if (md == 0) press_at_wrap(); else step(3);
         endcase
      end

      // Reset in the middle of operation, then the first tick again
      step(4);
      do_reset();
      step(12);
      check("post_reset_tick", 32'(time_bcd), 32'h000001);
      check("drain_end", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
